// File: rtl/cookie_frame_reader_if.sv
// Row stream from the cookie frame reader to the output formatter.
// Valid/ready handshake; master drives rows, slave accepts them.
interface cookie_frame_reader_if #(
   parameter int GRID_W = 16,
   parameter int GRID_H = 16
);
   localparam int IW = $clog2(GRID_H);

   logic [GRID_W-1:0] row_data;
   logic [IW-1:0]     row_idx;
   logic              row_valid;
   logic              row_ready;

   modport master (
      output row_data,
      output row_idx,
      output row_valid,
      input  row_ready
   );

   modport slave (
      input  row_data,
      input  row_idx,
      input  row_valid,
      output row_ready
   );
endinterface

// File: rtl/cookie_frame_reader.sv
// Reads one GRID_W x GRID_H frame off the cookie display chain into rows.
// Optional live-cell counter: define COOKIE_READER_POPCOUNT_EN.
module cookie_frame_reader #(
   parameter int GRID_W = 16,
   parameter int GRID_H = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic disp_load,
   output logic disp_shift,
   input  logic disp_bit,
   cookie_frame_reader_if.master rows,
   output logic busy,
   output logic frame_done
`ifdef COOKIE_READER_POPCOUNT_EN
   ,
   output logic [$clog2(GRID_W*GRID_H+1)-1:0] live_count
`endif
);
   localparam int TOTAL = GRID_W * GRID_H;
   localparam int BCW   = $clog2(TOTAL) + 1;
   localparam int CW    = $clog2(GRID_W);
   localparam int IW    = $clog2(GRID_H);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state;
   logic [2:0]        state_d;
   logic [BCW-1:0]    bit_cnt;
   logic [CW-1:0]     col_cnt;
   logic [GRID_W-1:0] asm_q;
   logic              asm_full;
   logic [IW-1:0]     next_idx;

   logic              hold_free;
   logic              shift_en;
   logic              row_done;
   logic              move_asm;
   logic              load_hold;
   logic              last_bit;
   logic [GRID_W-1:0] asm_next;
   logic [GRID_W-1:0] hold_d;

   // The holding register counts as free when it is empty or being
   // accepted on this edge, so rows can stream back to back.
   assign hold_free = !rows.row_valid || rows.row_ready;
   assign shift_en  = (state == S_SHIFT) && (!asm_full || hold_free);
   assign row_done  = shift_en && !asm_full
                      && (col_cnt == CW'(GRID_W - 1));
   assign move_asm  = asm_full && hold_free;
   assign load_hold = move_asm || (row_done && hold_free);
   assign last_bit  = shift_en && (bit_cnt == BCW'(TOTAL - 1));
   assign asm_next  = {asm_q[GRID_W-2:0], disp_bit};
   assign hold_d    = move_asm ? asm_q : asm_next;

   assign disp_load  = (state == S_LOAD);
   assign disp_shift = shift_en;
   assign busy       = (state != S_IDLE);
   assign frame_done = (state == S_DONE);

   always_comb begin
      state_d = state;
      unique case (state)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  state_d = S_SHIFT;
         S_SHIFT: if (last_bit) state_d = S_DRAIN;
         S_DRAIN: if (!asm_full && hold_free) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= S_IDLE;
         bit_cnt        <= '0;
         col_cnt        <= '0;
         asm_q          <= '0;
         asm_full       <= 1'b0;
         next_idx       <= '0;
         rows.row_data  <= '0;
         rows.row_idx   <= '0;
         rows.row_valid <= 1'b0;
      end else begin
         state <= state_d;
         if (state == S_LOAD) begin
            bit_cnt  <= '0;
            col_cnt  <= '0;
            asm_full <= 1'b0;
            next_idx <= IW'(GRID_H - 1);
         end
         // Stale bits left in asm_q shift out within one row.
         if (shift_en) begin
            bit_cnt <= bit_cnt + BCW'(1);
            col_cnt <= (col_cnt == CW'(GRID_W - 1)) ?
                       '0 : col_cnt + CW'(1);
            asm_q   <= asm_next;
         end
         if (move_asm)
            asm_full <= 1'b0;
         else if (row_done && !hold_free)
            asm_full <= 1'b1;
         if (load_hold) begin
            rows.row_data  <= hold_d;
            rows.row_idx   <= next_idx;
            rows.row_valid <= 1'b1;
            if (next_idx != '0)
               next_idx <= next_idx - IW'(1);
         end else if (rows.row_ready) begin
            rows.row_valid <= 1'b0;
         end
      end
   end

`ifdef COOKIE_READER_POPCOUNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         live_count <= '0;
      else if (state == S_LOAD)
         live_count <= '0;
      else if (shift_en && disp_bit)
         live_count <= live_count + 1'b1;
   end
`endif
endmodule

// File: tb/tb_cookie_frame_reader.sv
// Bench for cookie_frame_reader: chain model, row scoreboard,
// table-driven frames plus stall, start-glitch and mid-frame reset.
module tb_cookie_frame_reader;
   localparam int W     = 16;
   localparam int H     = 16;
   localparam int TOTAL = W * H;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic disp_load;
   logic disp_shift;
   logic disp_bit;
   logic busy;
   logic frame_done;
`ifdef COOKIE_READER_POPCOUNT_EN
   logic [8:0] live_count;
`endif

   cookie_frame_reader_if #(.GRID_W(W), .GRID_H(H)) rif ();

   cookie_frame_reader #(.GRID_W(W), .GRID_H(H)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .disp_load  (disp_load),
      .disp_shift (disp_shift),
      .disp_bit   (disp_bit),
      .rows       (rif.master),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef COOKIE_READER_POPCOUNT_EN
      ,
      .live_count (live_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int pat;
      int rdy;
      bit glitch;
      int exp_lat;
      int exp_live;
   } vec_t;

   typedef struct {
      logic [W-1:0] data;
      logic [3:0]   idx;
   } row_t;

   row_t           sb[$];
   logic [TOTAL-1:0] frame = '0;
   logic [8:0]     ptr = '0;
   int             n_vec = 0;
   int             n_err = 0;
   int             shift_cnt = 0;
   int             load_cnt = 0;
   int             done_cnt = 0;
   int             model_live = 0;
   logic           stall_q = 1'b0;
   row_t           stall_row;

   // Array chain: LOAD rewinds it, each shift advances one cell.
   assign disp_bit = frame[ptr[7:0]];
   always @(posedge clk) begin
      if (disp_load) ptr <= '0;
      else if (disp_shift) ptr <= ptr + 9'd1;
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (disp_shift) shift_cnt++;
         if (disp_load) load_cnt++;
         if (frame_done) done_cnt++;
         if (stall_q) begin
            chk("hold_valid", 32'(rif.row_valid), 32'd1);
            chk("hold_data", 32'(rif.row_data), 32'(stall_row.data));
            chk("hold_idx", 32'(rif.row_idx), 32'(stall_row.idx));
         end
         if (rif.row_valid && rif.row_ready) begin
            if (sb.size() == 0) begin
               chk("extra_row", 32'(sb.size()), 32'd1);
            end else begin
               row_t e;
               e = sb.pop_front();
               chk("row_data", 32'(rif.row_data), 32'(e.data));
               chk("row_idx", 32'(rif.row_idx), 32'(e.idx));
            end
         end
         stall_q = rif.row_valid && !rif.row_ready;
         stall_row.data = rif.row_data;
         stall_row.idx  = rif.row_idx;
      end
   end

   // Cell (x,y); the chain delivers row y=H-1 first, x=0 first.
   task automatic build_frame(input int pat);
      row_t r;
      model_live = 0;
      for (int k = 0; k < TOTAL; k++) begin
         int x, y;
         y = H - 1 - k / W;
         x = k % W;
         case (pat)
            0:       frame[k] = 1'b0;
            1:       frame[k] = 1'((x ^ y) & 1);
            2:       frame[k] = 1'b1;
            default: frame[k] = 1'($urandom_range(0, 1));
         endcase
         model_live += int'(frame[k]);
      end
      for (int i = 0; i < H; i++) begin
         for (int j = 0; j < W; j++)
            r.data[W-1-j] = frame[i*W + j];
         r.idx = 4'(H - 1 - i);
         sb.push_back(r);
      end
   endtask

   function automatic logic pick_ready(input int mode, input int n);
      case (mode)
         0:       return 1'b1;
         2:       return (n >= 60);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_load"}, 32'(disp_load), 32'd0);
      chk({tag, "_shift"}, 32'(disp_shift), 32'd0);
      chk({tag, "_valid"}, 32'(rif.row_valid), 32'd0);
      chk({tag, "_data"}, 32'(rif.row_data), 32'd0);
      chk({tag, "_idx"}, 32'(rif.row_idx), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(frame_done), 32'd0);
`ifdef COOKIE_READER_POPCOUNT_EN
      chk({tag, "_live"}, 32'(live_count), 32'd0);
`endif
   endtask

   task automatic run_frame(input vec_t v);
      int n;
      int first_valid;
      build_frame(v.pat);
      shift_cnt = 0;
      load_cnt  = 0;
      done_cnt  = 0;
      first_valid = 0;
      start = 1'b1;
      rif.row_ready = pick_ready(v.rdy, 0);
      @(posedge clk); #1;
      n = 1;
      while (!frame_done && n < 3000) begin
         if (first_valid == 0 && rif.row_valid) first_valid = n;
         start = v.glitch && (n == 50);
         if (v.rdy == 2 && n == 60) begin
            chk("stall_shifts", 32'(shift_cnt), 32'd32);
            chk("stall_shift_low", 32'(disp_shift), 32'd0);
            chk("stall_idx", 32'(rif.row_idx), 32'd15);
         end
         rif.row_ready = pick_ready(v.rdy, n);
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0;
      chk("done_seen", 32'(frame_done), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd1);
      if (v.exp_lat != 0) begin
         chk("done_latency", 32'(n), 32'(v.exp_lat));
         chk("first_valid", 32'(first_valid), 32'd18);
      end
      rif.row_ready = 1'b1;
      @(posedge clk); #1;
      chk("busy_after", 32'(busy), 32'd0);
      chk("done_pulse", 32'(frame_done), 32'd0);
      chk("shift_total", 32'(shift_cnt), 32'(TOTAL));
      chk("load_count", 32'(load_cnt), 32'd1);
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("rows_left", 32'(sb.size()), 32'd0);
`ifdef COOKIE_READER_POPCOUNT_EN
      chk("live_count", 32'(live_count),
          32'(v.exp_live < 0 ? model_live : v.exp_live));
`endif
      sb.delete();
   endtask

   vec_t tbl[6];

   initial begin
      int n;
      // pat: 0 zeros, 1 checker, 2 ones, 3 random
      // rdy: 0 always, 1 random, 2 held low then released
      tbl[0] = '{pat: 0, rdy: 0, glitch: 0, exp_lat: 259, exp_live: 0};
      tbl[1] = '{pat: 1, rdy: 0, glitch: 0, exp_lat: 259, exp_live: 128};
      tbl[2] = '{pat: 1, rdy: 2, glitch: 0, exp_lat: 0, exp_live: 128};
      tbl[3] = '{pat: 2, rdy: 1, glitch: 1, exp_lat: 0, exp_live: 256};
      tbl[4] = '{pat: 3, rdy: 1, glitch: 0, exp_lat: 0, exp_live: -1};
      tbl[5] = '{pat: 3, rdy: 0, glitch: 1, exp_lat: 259, exp_live: -1};

      rst = 1'b1;
      start = 1'b0;
      rif.row_ready = 1'b0;
      #1;
      check_idle_outputs("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 6; i++)
         run_frame(tbl[i]);

      // Reset lands mid-frame around bit 100.
      build_frame(3);
      shift_cnt = 0;
      start = 1'b1;
      rif.row_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 1;
      while (shift_cnt < 100 && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reach_bit100", 32'(shift_cnt), 32'd100);
      rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      @(posedge clk); #1;
      rst = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      run_frame(tbl[1]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
